// File: rtl/spi_frame_writer.sv
// Turns 3-byte SPI frames into board RAM writes, a held score and CLEAR sweeps.
// Chip select is synchronised into clk; its falling edge marks the frame end.
module spi_frame_writer #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH       = 768,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              resetB,
    input  logic              cs,
    input  logic [7:0]        command,
    input  logic [7:0]        databyte1,
    input  logic [7:0]        databyte2,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic [9:0]        score,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        drop_cnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [3:0] OP_WRITE_CELL = 4'h1;
    localparam logic [3:0] OP_SET_SCORE  = 4'h2;
    localparam logic [3:0] OP_CLEAR      = 4'h3;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        WRITE,
        CLEAR
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   cs_prev;
    logic [ADDR_W-1:0]      clr_addr;

    logic                   cs_fall_c;
    logic [3:0]             op_c;
    logic [ADDR_W-1:0]      cell_addr_c;
    logic                   cell_ok_c;

    // Frame end: synchronised chip select falling 1->0
    assign cs_fall_c   = cs_prev & ~cs_sync[SYNC_STAGES-1];
    assign op_c        = command[7:4];
    assign cell_addr_c = ADDR_W'({command[1:0], databyte1});
    assign cell_ok_c   = (cell_addr_c <= LAST_ADDR);

    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            state      <= IDLE;
            cs_sync    <= '0;
            cs_prev    <= 1'b0;
            clr_addr   <= '0;
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            score      <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            cs_sync    <= {cs_sync[SYNC_STAGES-2:0], cs};
            cs_prev    <= cs_sync[SYNC_STAGES-1];
            we         <= 1'b0;
            frame_done <= 1'b0;

            case (state)
                CLEAR: begin
                    // Frames arriving mid-sweep are dropped and counted
                    if (cs_fall_c && (drop_cnt != 8'hFF)) begin
                        drop_cnt <= drop_cnt + 8'd1;
                    end
                    if (clr_addr == LAST_ADDR) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        clr_addr <= clr_addr + ADDR_W'(1);
                        waddr    <= clr_addr + ADDR_W'(1);
                        we       <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    if (cs_fall_c) begin
                        frame_done <= 1'b1;
                        state      <= DECODE;
                        case (op_c)
                            OP_WRITE_CELL: begin
                                state <= WRITE;
                                if (cell_ok_c) begin
                                    we    <= 1'b1;
                                    waddr <= cell_addr_c;
                                    wdata <= DATA_W'(databyte2);
                                end
                            end
                            OP_SET_SCORE: begin
                                score <= {command[1:0], databyte1};
                            end
                            OP_CLEAR: begin
                                state    <= CLEAR;
                                busy     <= 1'b1;
                                we       <= 1'b1;
                                waddr    <= '0;
                                wdata    <= DATA_W'(databyte2);
                                clr_addr <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
